// File: rtl/uart_rx_param_if.sv
// Signal bundle between the UART receiver and the surrounding logic:
// frame configuration and serial input towards the receiver, decoded
// word, status pulses and busy flag back from it.
interface uart_rx_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic                  RX_IN;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    logic                  BUSY;

    modport master (
        output PRESCALE, PAR_EN, PAR_TYP, STOP2, RX_IN,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );

    modport slave (
        input  PRESCALE, PAR_EN, PAR_TYP, STOP2, RX_IN,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with run-time prescale, optional parity and
// one or two stop bits. Frames are reported as a DATA_VALID pulse or as
// PAR_ERR / STP_ERR pulses one cycle after the final stop decision.
// Optional feature macro: UART_RX_MAJ_VOTE_EN selects 2-of-3 majority
// sampling around mid-bit; without it a single sample is taken at the
// same decision point, so frame timing is identical in both builds.
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    uart_rx_param_if.slave  bus
);
    localparam int BC_W = $clog2(DATA_WIDTH);
    localparam logic [BC_W-1:0]       LAST_BIT = BC_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] P_ONE    = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    logic                  sync1_q, rx_s_q;
    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
    logic                  par_bad_q, par_bad_d;
    logic                  stp_bad_q, stp_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  busy_q, busy_d;

    logic [PRESCALE_W-1:0] half;
    logic                  at_dec, at_wrap, bit_val, stop_bad;

    assign half    = pre_q >> 1;
    assign at_dec  = (edge_cnt_q == half + P_ONE);
    assign at_wrap = (edge_cnt_q == pre_q - P_ONE);

`ifdef UART_RX_MAJ_VOTE_EN
    logic vote0_q, vote0_d, vote1_q, vote1_d;

    // Capture the two early mid-bit samples and vote with the current one
    always_comb begin
        vote0_d = vote0_q;
        vote1_d = vote1_q;
        if (edge_cnt_q == half - P_ONE) vote0_d = rx_s_q;
        if (edge_cnt_q == half)         vote1_d = rx_s_q;
        bit_val = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
    end

    // Voting sample registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else begin
            vote0_q <= vote0_d;
            vote1_q <= vote1_d;
        end
    end
`else
    assign bit_val = rx_s_q;
`endif

    // Two-flop synchroniser for the asynchronous serial line, idling high
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= bus.RX_IN;
            rx_s_q  <= sync1_q;
        end
    end

    // Next-state, counters, deserialiser and frame-completion outputs
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = at_wrap ? '0 : edge_cnt_q + P_ONE;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        shift_d      = shift_q;
        pre_d        = pre_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        stop2_d      = stop2_q;
        par_bad_d    = par_bad_q;
        stp_bad_d    = stp_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        stop_bad     = stp_bad_q | ~bit_val;
        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d    = S_START;
                    pre_d      = bus.PRESCALE;
                    par_en_d   = bus.PAR_EN;
                    par_typ_d  = bus.PAR_TYP;
                    stop2_d    = bus.STOP2;
                    par_bad_d  = 1'b0;
                    stp_bad_d  = 1'b0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            S_START: begin
                if (at_dec && bit_val) state_d = S_IDLE;
                else if (at_wrap)      state_d = S_DATA;
            end
            S_DATA: begin
                if (at_dec) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                if (at_wrap) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (at_dec && (bit_val != (^shift_q ^ par_typ_q))) par_bad_d = 1'b1;
                if (at_wrap) state_d = S_STOP;
            end
            S_STOP: begin
                if (at_dec) begin
                    stp_bad_d = stop_bad;
                    // Leave at the last stop's decision point so a start
                    // bit right behind it is not missed.
                    if (stop_cnt_q == stop2_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = ~par_bad_q & ~stop_bad;
                        par_err_d    = par_bad_q;
                        stp_err_d    = stop_bad;
                        state_d      = stop_bad ? S_WAIT_IDLE : S_IDLE;
                    end
                end else if (at_wrap) begin
                    stop_cnt_d = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Receiver state and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            pre_q        <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            stop2_q      <= 1'b0;
            par_bad_q    <= 1'b0;
            stp_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            shift_q      <= shift_d;
            pre_q        <= pre_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            stop2_q      <= stop2_d;
            par_bad_q    <= par_bad_d;
            stp_bad_q    <= stp_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;
    assign bus.BUSY       = busy_q;
endmodule
